// File: rtl/humidity_pkg.sv
// Shared types and display constants for the soil-humidity monitor and its
// downstream 7-segment decoder.
package humidity_pkg;

    // Alarm FSM states
    typedef enum logic [1:0] {
        S_OK    = 2'd0,
        S_DRY   = 2'd1,
        S_ACKED = 2'd2
    } hum_state_t;

    // Segment patterns (gfedcba, 1 = segment lit) used by the SEG decoder
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_DRY   = 7'b101_1110;  // 'd'
    localparam logic [6:0] SEG_WET   = 7'b101_1100;  // 'o'

    // Segment pattern for one hum_code bit
    function automatic logic [6:0] seg_for_bit(input logic low_humidity);
        seg_for_bit = low_humidity ? SEG_DRY : SEG_WET;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-sensor debouncer: the filtered bit flips only after DEBOUNCE_CYCLES
// consecutive samples that disagree with it.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_2,
    input  logic reset,
    input  logic sample,
    output logic filt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_r;
    logic          filt_r;

    // Mismatch run counter and filtered flop
    always_ff @(posedge clk_2) begin
        if (reset) begin
            cnt_r  <= {CW{1'b0}};
            filt_r <= 1'b0;
        end else if (sample != filt_r) begin
            if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
                filt_r <= ~filt_r;
                cnt_r  <= {CW{1'b0}};
            end else begin
                cnt_r  <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    assign filt = filt_r;

endmodule

// File: rtl/humidity_monitor.sv
// Debounces the raw dry/wet sensor bits, runs the alarm FSM with operator
// acknowledge and escalation, and counts alarm entries (saturating).
module humidity_monitor
    import humidity_pkg::*;
#(
    parameter int NSENS           = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NSENS-1:0] sensor_raw,
    input  logic             ack,
    output logic [NSENS-1:0] hum_code,
    output logic             alarm,
    output logic [NSENS-1:0] ack_mask,
    output logic [CNT_W-1:0] event_count
);

    logic [NSENS-1:0] filt_s;
    logic             dry_s;
    hum_state_t       state_r;
    hum_state_t       state_next_s;
    logic [NSENS-1:0] ack_mask_r;
    logic [NSENS-1:0] mask_next_s;
    logic             inc_s;
    logic             alarm_r;
    logic [CNT_W-1:0] event_count_r;

    for (genvar i = 0; i < NSENS; i++) begin : g_deb
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_2  (clk_2),
            .reset  (reset),
            .sample (sensor_raw[i]),
            .filt   (filt_s[i])
        );
    end

    assign dry_s = |filt_s;

    // Next-state, next-mask and event-increment decode
    always_comb begin
        state_next_s = state_r;
        mask_next_s  = ack_mask_r;
        inc_s        = 1'b0;
        case (state_r)
            S_OK: begin
                if (dry_s) begin
                    state_next_s = S_DRY;
                    inc_s        = 1'b1;
                end else begin
                    state_next_s = S_OK;
                end
            end
            S_DRY: begin
                if (!dry_s) begin
                    state_next_s = S_OK;
                    mask_next_s  = {NSENS{1'b0}};
                end else if (ack) begin
                    state_next_s = S_ACKED;
                    mask_next_s  = filt_s;
                end else begin
                    state_next_s = S_DRY;
                end
            end
            S_ACKED: begin
                if (!dry_s) begin
                    state_next_s = S_OK;
                    mask_next_s  = {NSENS{1'b0}};
                end else if ((filt_s & ~ack_mask_r) != {NSENS{1'b0}}) begin
                    // a sensor outside the acknowledged set went dry
                    state_next_s = S_DRY;
                    inc_s        = 1'b1;
                end else begin
                    mask_next_s  = ack_mask_r & filt_s;
                end
            end
            default: begin
                state_next_s = S_OK;
                mask_next_s  = {NSENS{1'b0}};
            end
        endcase
    end

    // State, mask, alarm flag and saturating event counter registers
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_r       <= S_OK;
            ack_mask_r    <= {NSENS{1'b0}};
            alarm_r       <= 1'b0;
            event_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            ack_mask_r <= mask_next_s;
            // alarm tracks the state register exactly, decoded from its next value
            alarm_r    <= (state_next_s == S_DRY);
            if (inc_s && (event_count_r != {CNT_W{1'b1}})) begin
                event_count_r <= event_count_r + CNT_W'(1);
            end else begin
                event_count_r <= event_count_r;
            end
        end
    end

    assign hum_code    = filt_s;
    assign alarm       = alarm_r;
    assign ack_mask    = ack_mask_r;
    assign event_count = event_count_r;

endmodule

// File: tb/tb_humidity_monitor.sv
// Bench for humidity_monitor: directed vector table, hand-written corner
// sequences, and randomized stimulus against a behavioural model. A second
// instance with a 2-bit counter exercises saturation.
module tb_humidity_monitor;

    localparam int DEB = 4;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [1:0] sensor_raw;
    logic       ack;
    logic [1:0] hum_code, hum_code_b;
    logic       alarm, alarm_b;
    logic [1:0] ack_mask, ack_mask_b;
    logic [7:0] event_count;
    logic [1:0] event_count_b;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [1:0] m_filt;
    int         m_run [2];
    int         m_state;   // 0 ok, 1 dry-unacknowledged, 2 acknowledged
    logic [1:0] m_mask;
    int         m_ev;

    always #5 clk_2 = ~clk_2;

    humidity_monitor #(.NSENS(2), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)) u_dut (
        .clk_2(clk_2), .reset(reset), .sensor_raw(sensor_raw), .ack(ack),
        .hum_code(hum_code), .alarm(alarm), .ack_mask(ack_mask),
        .event_count(event_count)
    );

    humidity_monitor #(.NSENS(2), .DEBOUNCE_CYCLES(DEB), .CNT_W(2)) u_dut_sat (
        .clk_2(clk_2), .reset(reset), .sensor_raw(sensor_raw), .ack(ack),
        .hum_code(hum_code_b), .alarm(alarm_b), .ack_mask(ack_mask_b),
        .event_count(event_count_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, applied to the inputs present at that edge
    task automatic model_edge();
        bit dry;
        if (reset) begin
            m_filt  = 2'b00;
            m_run[0] = 0;
            m_run[1] = 0;
            m_state = 0;
            m_mask  = 2'b00;
            m_ev    = 0;
        end else begin
            dry = (m_filt != 2'b00);
            case (m_state)
                0: if (dry) begin m_state = 1; m_ev++; end
                1: begin
                    if (!dry) begin m_state = 0; m_mask = 2'b00; end
                    else if (ack) begin m_state = 2; m_mask = m_filt; end
                end
                2: begin
                    if (!dry) begin m_state = 0; m_mask = 2'b00; end
                    else if ((m_filt & ~m_mask) != 2'b00) begin m_state = 1; m_ev++; end
                    else m_mask = m_mask & m_filt;
                end
                default: m_state = 0;
            endcase
            for (int i = 0; i < 2; i++) begin
                if (sensor_raw[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_filt[i] = ~m_filt[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    // One clock: advance model, then compare both instances against it
    task automatic tick();
        @(posedge clk_2);
        model_edge();
        #1;
        chk("model hum_code", int'(hum_code), int'(m_filt));
        chk("model alarm", int'(alarm), (m_state == 1) ? 1 : 0);
        chk("model ack_mask", int'(ack_mask), int'(m_mask));
        chk("model event_count", int'(event_count), (m_ev > 255) ? 255 : m_ev);
        chk("model sat hum_code", int'(hum_code_b), int'(m_filt));
        chk("model sat alarm", int'(alarm_b), (m_state == 1) ? 1 : 0);
        chk("model sat ack_mask", int'(ack_mask_b), int'(m_mask));
        chk("model sat event_count", int'(event_count_b), (m_ev > 3) ? 3 : m_ev);
    endtask

    task automatic drive(input logic r, input logic [1:0] raw, input logic a);
        reset      = r;
        sensor_raw = raw;
        ack        = a;
    endtask

    typedef struct packed {
        logic       rst;
        logic [1:0] raw;
        logic       ack;
        logic [1:0] hum;
        logic       alarm;
        logic [1:0] mask;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [1:0] raw, input logic a,
                                input logic [1:0] h, input logic al,
                                input logic [1:0] m, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.raw = raw; v.ack = a;
        v.hum = h; v.alarm = al; v.mask = m; v.cnt = c;
        return v;
    endfunction

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        drive(1'b1, 2'b00, 1'b0);
        m_filt = 2'b00; m_run[0] = 0; m_run[1] = 0;
        m_state = 0; m_mask = 2'b00; m_ev = 0;

        // reset
        tbl.push_back(mk(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 8'd0));
        // glitch of 3 edges on sensor 1 is filtered
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 8'd0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 8'd0));
        // sensor 0 dry: hum_code after 4 edges, alarm one edge later
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 8'd0));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00, 8'd0));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 8'd1));
        // acknowledge, then escalation by sensor 1, then re-ack
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 2'b01, 8'd1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 2'b01, 8'd1));
        tbl.push_back(mk(1'b0, 2'b11, 1'b0, 2'b11, 1'b0, 2'b01, 8'd1));
        tbl.push_back(mk(1'b0, 2'b11, 1'b0, 2'b11, 1'b1, 2'b01, 8'd2));
        tbl.push_back(mk(1'b0, 2'b11, 1'b1, 2'b11, 1'b0, 2'b11, 8'd2));
        // recovery from acknowledged state
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 2'b11, 8'd2));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b11, 8'd2));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 8'd2));
        // dry again, then recovery beats ack; ack in OK ignored
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 8'd2));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00, 8'd2));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 8'd3));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 8'd3));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 8'd3));
        tbl.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 8'd3));
        tbl.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 8'd3));

        @(negedge clk_2);
        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].raw, tbl[k].ack);
            tick();
            chk($sformatf("tbl[%0d] hum_code", k), int'(hum_code), int'(tbl[k].hum));
            chk($sformatf("tbl[%0d] alarm", k), int'(alarm), int'(tbl[k].alarm));
            chk($sformatf("tbl[%0d] ack_mask", k), int'(ack_mask), int'(tbl[k].mask));
            chk($sformatf("tbl[%0d] event_count", k), int'(event_count), int'(tbl[k].cnt));
        end

        // reset while acknowledged and mid-debounce (cnt=2)
        for (int i = 0; i < 5; i++) begin drive(1'b0, 2'b01, 1'b0); tick(); end
        drive(1'b0, 2'b01, 1'b1); tick();
        chk("pre-reset ack_mask", int'(ack_mask), 1);
        for (int i = 0; i < 2; i++) begin drive(1'b0, 2'b00, 1'b0); tick(); end
        chk("pre-reset hum_code", int'(hum_code), 1);
        drive(1'b1, 2'b00, 1'b0); tick();
        chk("reset hum_code", int'(hum_code), 0);
        chk("reset alarm", int'(alarm), 0);
        chk("reset ack_mask", int'(ack_mask), 0);
        chk("reset event_count", int'(event_count), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 1'b0); tick();
            chk("post-reset hum_code", int'(hum_code), 0);
            chk("post-reset alarm", int'(alarm), 0);
        end

        // saturation of the 2-bit counter over 5 dry/recover cycles
        drive(1'b1, 2'b00, 1'b0); tick();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 5; i++) begin drive(1'b0, 2'b01, 1'b0); tick(); end
            chk($sformatf("sat cycle %0d event_count", c), int'(event_count_b), sat_exp[c]);
            chk($sformatf("wide cycle %0d event_count", c), int'(event_count), c + 1);
            for (int i = 0; i < 5; i++) begin drive(1'b0, 2'b00, 1'b0); tick(); end
        end

        // randomized stimulus against the model
        drive(1'b1, 2'b00, 1'b0); tick();
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] raw;
            raw = sensor_raw;
            if ($urandom_range(0, 5) == 0) raw = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 199) == 0), raw, ($urandom_range(0, 3) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
